// File: rtl/axi_stream_slave_rx.sv
// ---------------------------------------------------------------------------
// axi_stream_slave_rx
//
// AXI-Stream receiver for the video pixel path. Accepted beats are checked
// against the expected frame geometry and stored in a small first-word-fall-
// through FIFO that feeds the image-processing pipeline. Beats that arrive
// before the first start-of-frame are accepted and discarded so the link
// never stalls while the receiver waits to lock onto a frame.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   s_axis_tdata    stream data
//   s_axis_tvalid   upstream beat valid
//   s_axis_tready   receiver can accept a beat (registered)
//   s_axis_tlast    end of line marker
//   s_axis_tuser    start of frame marker
//   data_out        FIFO head data (0 when empty)
//   valid_out       FIFO holds at least one entry
//   ready_in        consumer takes the head this cycle
//   last_out        tlast stored with the head (0 when empty)
//   user_out        tuser stored with the head (0 when empty)
//   pixel_cnt       index of the next expected pixel in the current line
//   line_cnt        index of the current line
//   frame_done      one-cycle pulse after the last beat of a frame
//   err_early_last  one-cycle pulse: tlast before the end of the line
//   err_late_last   one-cycle pulse: line ended without tlast
//   err_sof         one-cycle pulse: start of frame in the middle of a frame
// ---------------------------------------------------------------------------
module axi_stream_slave_rx #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int PIXELS_PER_LINE = 640,
  parameter int LINES_PER_FRAME = 480
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic                                 s_axis_tuser,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic                                 valid_out,
  input  logic                                 ready_in,
  output logic                                 last_out,
  output logic                                 user_out,
  output logic [$clog2(PIXELS_PER_LINE)-1:0]   pixel_cnt,
  output logic [$clog2(LINES_PER_FRAME):0]     line_cnt,
  output logic                                 frame_done,
  output logic                                 err_early_last,
  output logic                                 err_late_last,
  output logic                                 err_sof
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PIXELS_PER_LINE);
  localparam int LW = $clog2(LINES_PER_FRAME) + 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [PW-1:0] LAST_PIX  = PW'(PIXELS_PER_LINE - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_FRAME - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  // FIFO storage; each entry is {tuser, tlast, tdata}
  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tready_q, tready_d;

  state_t        state_q, state_d;
  logic [PW-1:0] pixel_cnt_q, pixel_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          err_early_q, err_early_d;
  logic          err_late_q, err_late_d;
  logic          err_sof_q, err_sof_d;

  logic          accept;
  logic          push;
  logic          pop;
  logic          line_close;
  logic [LW-1:0] closed_line;
  logic [EW-1:0] head;

  assign accept = s_axis_tvalid && tready_q;
  assign pop    = (count_q != '0) && ready_in;

  // Framing checker: decides whether an accepted beat is stored and tracks
  // the position of the next beat inside the frame.
  always_comb begin
    state_d      = state_q;
    pixel_cnt_d  = pixel_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    err_early_d  = 1'b0;
    err_late_d   = 1'b0;
    err_sof_d    = 1'b0;
    push         = 1'b0;
    line_close   = 1'b0;
    closed_line  = line_cnt_q;

    if (accept) begin
      if (s_axis_tuser) begin
        // Any SOF restarts geometry tracking; inside a frame it is an error.
        push        = 1'b1;
        err_sof_d   = (state_q == IN_FRAME);
        state_d     = IN_FRAME;
        pixel_cnt_d = PW'(1);
        line_cnt_d  = '0;
        if (s_axis_tlast) begin
          // The SOF beat is pixel 0, so a tlast on it is always early.
          err_early_d = 1'b1;
          line_close  = 1'b1;
          closed_line = '0;
        end
      end else if (state_q == IN_FRAME) begin
        push = 1'b1;
        if (s_axis_tlast || (pixel_cnt_q == LAST_PIX)) begin
          err_early_d = s_axis_tlast && (pixel_cnt_q < LAST_PIX);
          err_late_d  = !s_axis_tlast;
          line_close  = 1'b1;
          closed_line = line_cnt_q;
        end else begin
          pixel_cnt_d = pixel_cnt_q + PW'(1);
        end
      end
    end

    // Closing the last line of the frame completes the frame.
    if (line_close) begin
      pixel_cnt_d = '0;
      if (closed_line == LAST_LINE) begin
        frame_done_d = 1'b1;
        line_cnt_d   = '0;
        state_d      = WAIT_SOF;
      end else begin
        line_cnt_d = closed_line + LW'(1);
      end
    end
  end

  // FIFO pointer and occupancy bookkeeping. tready is registered from the
  // next occupancy so it never depends on tvalid in the same cycle.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    tready_d = (count_d < DEPTH_C);
  end

  // All control state and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tready_q     <= 1'b0;
      state_q      <= WAIT_SOF;
      pixel_cnt_q  <= '0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      err_early_q  <= 1'b0;
      err_late_q   <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tready_q     <= tready_d;
      state_q      <= state_d;
      pixel_cnt_q  <= pixel_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
      err_early_q  <= err_early_d;
      err_late_q   <= err_late_d;
      err_sof_q    <= err_sof_d;
    end
  end

  // Storage needs no reset: the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  // Head entry is forced to zero when the FIFO is empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    valid_out = (count_q != '0);
    data_out  = '0;
    last_out  = 1'b0;
    user_out  = 1'b0;
    if (valid_out) begin
      data_out = head[DATA_WIDTH-1:0];
      last_out = head[DATA_WIDTH];
      user_out = head[DATA_WIDTH+1];
    end
  end

  assign s_axis_tready  = tready_q;
  assign pixel_cnt      = pixel_cnt_q;
  assign line_cnt       = line_cnt_q;
  assign frame_done     = frame_done_q;
  assign err_early_last = err_early_q;
  assign err_late_last  = err_late_q;
  assign err_sof        = err_sof_q;

endmodule
